// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: stall/flush bus shapes, stage indices and skid-stage state encoding.
package pipe_skid_reg_pkg;

  localparam int unsigned STAGE_CNT = 5;

  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;
  localparam int unsigned STAGE_WB  = 4;

  // All-zero control word is a pipeline bubble.
  localparam int unsigned CTRL_NOP = 0;

  typedef logic [STAGE_CNT-1:0] stall_bus_t;
  typedef logic [STAGE_CNT-1:0] flush_bus_t;

  // Encoded as {main_v, skid_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Upstream ready is a flop; flush bubbles the stage and optionally keeps the incoming pc.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned STAGE   = STAGE_EX,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CTRL_W  = 16,
  parameter bit          KEEP_PC = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  stall_bus_t        stall_i,
  input  flush_bus_t        flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  skid_state_e       state;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic stall_en;
  logic flush_en;
  logic rdy_eff;
  logic take_in;
  logic take_out;

  // Other stages' enables are intentionally ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{stall_i, flush_i};

  assign stall_en = stall_i[STAGE];
  assign flush_en = flush_i[STAGE];

  assign up_ready_o = (state != ST_FULL);
  assign dn_valid_o = (state != ST_EMPTY);

  assign rdy_eff  = dn_ready_i & ~stall_en;
  assign take_in  = up_valid_i & up_ready_o;
  assign take_out = dn_valid_o & rdy_eff;

  // Main register drives the outputs; skid only ever refills main.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      pc_o      <= '0;
      data_o    <= '0;
      ctrl_o    <= '0;
      skid_pc   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush_en) begin
      state     <= ST_EMPTY;
      pc_o      <= KEEP_PC ? pc_i : '0;
      data_o    <= '0;
      ctrl_o    <= CTRL_W'(CTRL_NOP);
      skid_pc   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (take_in) begin
            pc_o   <= pc_i;
            data_o <= data_i;
            ctrl_o <= ctrl_i;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (take_in && take_out) begin
            pc_o   <= pc_i;
            data_o <= data_i;
            ctrl_o <= ctrl_i;
          end else if (take_in) begin
            skid_pc   <= pc_i;
            skid_data <= data_i;
            skid_ctrl <= ctrl_i;
            state     <= ST_FULL;
          end else if (take_out) begin
            pc_o   <= '0;
            data_o <= '0;
            ctrl_o <= CTRL_W'(CTRL_NOP);
            state  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take_out) begin
            pc_o      <= skid_pc;
            data_o    <= skid_data;
            ctrl_o    <= skid_ctrl;
            skid_pc   <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            state     <= ST_BUSY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (dn_valid_o & ~take_out),
    .cnt (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .inc (~dn_valid_o),
    .cnt (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: occupancy/queue reference model checked every cycle plus directed scenarios.
module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  localparam int unsigned STG    = 2;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  stall_bus_t        stall_i;
  flush_bus_t        flush_i;
  logic              up_valid_i;
  logic [PC_W-1:0]   pc_i;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              dn_ready_i;

  logic              up_ready_o, dn_valid_o;
  logic [PC_W-1:0]   pc_o;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;

  logic              k0_up_ready, k0_dn_valid;
  logic [PC_W-1:0]   k0_pc;
  logic [DATA_W-1:0] k0_data;
  logic [CTRL_W-1:0] k0_ctrl;
  logic [CNT_W-1:0]  k0_stall_cnt, k0_bubble_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .STAGE(STG), .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .KEEP_PC(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
    .pc_i(pc_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
    .pc_o(pc_o), .data_o(data_o), .ctrl_o(ctrl_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  pipe_skid_reg #(
    .STAGE(STG), .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .KEEP_PC(1'b0), .CNT_W(CNT_W)
  ) dut_k0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(k0_up_ready),
    .pc_i(pc_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .dn_valid_o(k0_dn_valid), .dn_ready_i(dn_ready_i),
    .pc_o(k0_pc), .data_o(k0_data), .ctrl_o(k0_ctrl),
    .stall_cnt_o(k0_stall_cnt), .bubble_cnt_o(k0_bubble_cnt)
  );

  beat_t           sb[$];
  int              n_chk = 0;
  int              n_err = 0;
  int              exp_stall = 0;
  int              exp_bubble = 0;
  bit              mv = 1'b0;
  bit              fchk = 1'b0;
  logic [PC_W-1:0] fpc = '0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted beats, sampled between edges.
  always @(negedge clk) begin
    int    occ;
    bit    t_out;
    beat_t f;
    occ   = sb.size();
    t_out = 1'b0;
    if (mv) begin
      check("dn_valid", 128'(dn_valid_o), 128'(occ > 0));
      check("up_ready", 128'(up_ready_o), 128'(occ < 2));
      check("stall_cnt", 128'(stall_cnt_o), 128'(exp_stall));
      check("bubble_cnt", 128'(bubble_cnt_o), 128'(exp_bubble));
      if (occ == 0) check("ctrl_idle", 128'(ctrl_o), 128'(0));
      if (fchk) begin
        check("flush_pc_keep", 128'(pc_o), 128'(fpc));
        check("flush_pc_clear", 128'(k0_pc), 128'(0));
        check("flush_data", 128'(data_o), 128'(0));
        check("flush_k0_valid", 128'(k0_dn_valid), 128'(0));
      end
      t_out = (occ > 0) && dn_ready_i && !stall_i[STG];
      if (t_out) begin
        f = sb.pop_front();
        check("out_pc", 128'(pc_o), 128'(f.pc));
        check("out_data", 128'(data_o), 128'(f.data));
        check("out_ctrl", 128'(ctrl_o), 128'(f.ctrl));
      end
    end
    fchk = 1'b0;
    if (rst) begin
      sb.delete();
      exp_stall  = 0;
      exp_bubble = 0;
      mv = 1'b1;
    end else if (mv) begin
      if (occ > 0 && !t_out && exp_stall < CNT_MAX) exp_stall++;
      if (occ == 0 && exp_bubble < CNT_MAX) exp_bubble++;
      if (flush_i[STG]) begin
        sb.delete();
        fchk = 1'b1;
        fpc  = pc_i;
      end else if (up_valid_i && occ < 2) begin
        sb.push_back('{pc: pc_i, data: data_i, ctrl: ctrl_i});
      end
    end
  end

  task automatic step(input bit v, input logic [PC_W-1:0] pc, input bit rdy,
                      input logic [STAGE_CNT-1:0] st, input bit fl);
    up_valid_i = v;
    pc_i       = pc;
    data_i     = {~pc, pc};
    ctrl_i     = pc[15:0] | 16'h0001;
    dn_ready_i = rdy;
    stall_i    = st;
    flush_i    = fl ? flush_bus_t'(1 << STG) : flush_bus_t'(0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [STAGE_CNT-1:0] NO_STG = ~STAGE_CNT'(1 << STG);
  localparam logic [STAGE_CNT-1:0] ST_STG = STAGE_CNT'(1 << STG);

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           STAGE_CNT'($urandom), 1'($urandom_range(0, 1)));
    check("rst_valid", 128'(dn_valid_o), 128'(0));
    check("rst_ctrl", 128'(ctrl_o), 128'(0));
    check("rst_pc", 128'(pc_o), 128'(0));
    check("rst_ready", 128'(up_ready_o), 128'(1));
    check("rst_stall_cnt", 128'(stall_cnt_o), 128'(0));
    check("rst_bubble_cnt", 128'(bubble_cnt_o), 128'(0));
    rst = 1'b0;

    // Back-to-back beats; other stages' stall bits toggle.
    step(1, 32'h100, 1, STAGE_CNT'($urandom) & NO_STG, 0);
    step(1, 32'h104, 1, STAGE_CNT'($urandom) & NO_STG, 0);
    step(1, 32'h108, 1, STAGE_CNT'($urandom) & NO_STG, 0);
    step(0, 32'h0, 1, STAGE_CNT'($urandom) & NO_STG, 0);
    step(0, 32'h0, 1, NO_STG, 0);

    // Downstream back-pressure for three cycles.
    step(1, 32'h110, 1, '0, 0);
    step(1, 32'h114, 0, '0, 0);
    step(0, 32'h0, 0, '0, 0);
    step(0, 32'h0, 0, '0, 0);
    step(0, 32'h0, 1, '0, 0);
    step(0, 32'h0, 1, '0, 0);
    check("stall_cnt_bp", 128'(stall_cnt_o), 128'(3));

    // Same pattern via this stage's stall bit.
    step(1, 32'h120, 1, '0, 0);
    step(1, 32'h124, 1, ST_STG, 0);
    step(0, 32'h0, 1, ST_STG, 0);
    step(0, 32'h0, 1, ST_STG, 0);
    step(0, 32'h0, 1, '0, 0);
    step(0, 32'h0, 1, '0, 0);
    check("stall_cnt_st", 128'(stall_cnt_o), 128'(6));

    // Flush while FULL.
    step(1, 32'h130, 1, '0, 0);
    step(1, 32'h134, 0, '0, 0);
    step(1, 32'h200, 0, '0, 1);
    check("fl_valid", 128'(dn_valid_o), 128'(0));
    check("fl_pc", 128'(pc_o), 128'(32'h200));
    check("fl_pc_k0", 128'(k0_pc), 128'(0));
    check("fl_ready", 128'(up_ready_o), 128'(1));

    // Flush coincident with take_in.
    step(1, 32'h300, 1, '0, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, '0, 0);

    // Reset mid-transfer.
    step(1, 32'h400, 0, '0, 0);
    step(1, 32'h404, 0, '0, 0);
    rst = 1'b1;
    step(0, 32'h0, 1, '0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, '0, 0);

    // Idle long enough to saturate the bubble counter.
    for (int i = 0; i < 20; i++) step(0, 32'h0, 1, '0, 0);
    check("bubble_sat", 128'(bubble_cnt_o), 128'(CNT_MAX));

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), PC_W'(32'h1000 + i * 4), ($urandom_range(0, 3) != 0),
           STAGE_CNT'($urandom) & (($urandom_range(0, 2) == 0) ? ~NO_STG | NO_STG : NO_STG),
           ($urandom_range(0, 15) == 0));

    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, '0, 0);
    check("drained", 128'(dn_valid_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
